// File: rtl/decompress_pkg.sv
// Shared widths, cosine/quant ROMs, FSM state and rounding helper for
// decompress_block. Optional dequantizer: DECOMP_DEQUANT_EN.
package decompress_pkg;

  localparam int COEFF_W  = 16;
  localparam int PIX_W    = 9;
  localparam int COS_FRAC = 12;
  localparam int INT_W    = 24;
  localparam int COS_W    = 14;
  localparam int Q_W      = 8;
  localparam int ACC_W    = 48;
  localparam int PROD_W   = INT_W + COS_W;
  localparam int CNT_W    = 9;

  localparam logic signed [ACC_W-1:0] RND_HALF = 48'sd2048;
  localparam logic signed [ACC_W-1:0] T_MAX    = 48'sd8388607;
  localparam logic signed [ACC_W-1:0] T_MIN    = -48'sd8388608;
  localparam logic signed [ACC_W-1:0] P_MAX    = 48'sd127;
  localparam logic signed [ACC_W-1:0] P_MIN    = -48'sd128;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_ROW,
    S_COL,
    S_DONE
  } state_t;

  // COS_ROM[x][u] = round(4096 * c(u)/2 * cos((2x+1)u*pi/16))
  localparam logic signed [COS_W-1:0] COS_ROM [8][8] = '{
    '{14'sd1448,  14'sd2009,  14'sd1892,  14'sd1703,
      14'sd1448,  14'sd1138,  14'sd784,   14'sd400},
    '{14'sd1448,  14'sd1703,  14'sd784,  -14'sd400,
     -14'sd1448, -14'sd2009, -14'sd1892, -14'sd1138},
    '{14'sd1448,  14'sd1138, -14'sd784,  -14'sd2009,
     -14'sd1448,  14'sd400,   14'sd1892,  14'sd1703},
    '{14'sd1448,  14'sd400,  -14'sd1892, -14'sd1138,
      14'sd1448,  14'sd1703, -14'sd784,  -14'sd2009},
    '{14'sd1448, -14'sd400,  -14'sd1892,  14'sd1138,
      14'sd1448, -14'sd1703, -14'sd784,   14'sd2009},
    '{14'sd1448, -14'sd1138, -14'sd784,   14'sd2009,
     -14'sd1448, -14'sd400,   14'sd1892, -14'sd1703},
    '{14'sd1448, -14'sd1703,  14'sd784,   14'sd400,
     -14'sd1448,  14'sd2009, -14'sd1892,  14'sd1138},
    '{14'sd1448, -14'sd2009,  14'sd1892, -14'sd1703,
      14'sd1448, -14'sd1138,  14'sd784,  -14'sd400}
  };

  localparam logic [Q_W-1:0] QTAB [8][8] = '{
    '{8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61},
    '{8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55},
    '{8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56},
    '{8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62},
    '{8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77},
    '{8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92},
    '{8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101},
    '{8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99}
  };

  // +half then arithmetic shift: ties round toward +inf
  function automatic logic signed [INT_W-1:0] round_clamp(
    input logic signed [ACC_W-1:0] acc,
    input logic signed [ACC_W-1:0] lo,
    input logic signed [ACC_W-1:0] hi
  );
    logic signed [ACC_W-1:0] r;
    r = (acc + RND_HALF) >>> COS_FRAC;
    if (r < lo) r = lo;
    else if (r > hi) r = hi;
    return r[INT_W-1:0];
  endfunction

endpackage

// File: rtl/decompress_block_idct_mac.sv
// Shared multiply-accumulate for both IDCT passes. o_acc already
// includes the current term so the final sum is usable the same cycle.
module idct_mac
  import decompress_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clear,
  input  logic                    i_enable,
  input  logic signed [INT_W-1:0] i_a,
  input  logic signed [COS_W-1:0] i_b,
  output logic signed [ACC_W-1:0] o_acc
);

  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_ext;
  logic signed [ACC_W-1:0]  w_base;
  logic signed [ACC_W-1:0]  r_acc;

  assign w_prod = i_a * i_b;
  assign w_ext  = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
  assign w_base = i_clear ? '0 : r_acc;
  assign o_acc  = w_base + w_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_enable) begin
      r_acc <= o_acc;
    end
  end

endmodule

// File: rtl/decompress_block.sv
// 8x8 dequant + separable 2-D IDCT on one shared MAC, 1025-cycle latency.
// Dequantization is built only when DECOMP_DEQUANT_EN is defined.
module decompress_block
  import decompress_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_block,
  input  logic [7:0][7:0][COEFF_W-1:0]     quantized_coeffs,
  output logic [7:0][7:0][PIX_W-1:0]       block,
  output logic                             block_done,
  output logic                             busy
);

  state_t r_state;
  state_t w_next;

  logic [CNT_W-1:0]                 r_cnt;
  logic [7:0][7:0][COEFF_W-1:0]     r_lvl;
  logic signed [INT_W-1:0]          r_t [8][8];
  logic [7:0][7:0][PIX_W-1:0]       r_blk;

  logic [2:0]                w_in;
  logic [2:0]                w_mid;
  logic [2:0]                w_out;
  logic                      w_row;
  logic                      w_col;
  logic                      w_last;
  logic                      w_wb;
  logic signed [COEFF_W-1:0] w_lvl;
  logic signed [INT_W-1:0]   w_d;
  logic signed [INT_W-1:0]   w_a;
  logic signed [COS_W-1:0]   w_b;
  logic signed [ACC_W-1:0]   w_acc;

  // ROW: v=out, x=mid, u=in.  COL: y=out, x=mid, v=in.
  assign w_in   = r_cnt[2:0];
  assign w_mid  = r_cnt[5:3];
  assign w_out  = r_cnt[8:6];
  assign w_row  = (r_state == S_ROW);
  assign w_col  = (r_state == S_COL);
  assign w_last = (r_cnt == '1);
  assign w_wb   = (w_in == 3'd7);
  assign w_lvl  = r_lvl[w_out][w_in];

`ifdef DECOMP_DEQUANT_EN
  logic signed [INT_W-1:0] w_lvl_x;
  logic signed [INT_W-1:0] w_q;

  assign w_lvl_x = INT_W'(w_lvl);
  assign w_q     = INT_W'(QTAB[w_out][w_in]);
  assign w_d     = w_lvl_x * w_q;
`else
  assign w_d = INT_W'(w_lvl);
`endif

  assign w_a = w_row ? w_d : r_t[w_in][w_mid];
  assign w_b = w_row ? COS_ROM[w_mid][w_in]
                     : COS_ROM[w_out][w_in];

  idct_mac u_mac (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_in == 3'd0),
    .i_enable (w_row | w_col),
    .i_a      (w_a),
    .i_b      (w_b),
    .o_acc    (w_acc)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (start_block) w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_ROW;
      S_ROW:     if (w_last) w_next = S_COL;
      S_COL:     if (w_last) w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == S_CAPTURE) begin
      r_cnt <= '0;
    end else if (w_row || w_col) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lvl <= '0;
    end else if (r_state == S_IDLE && start_block) begin
      r_lvl <= quantized_coeffs;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        for (int j = 0; j < 8; j++) begin
          r_t[i][j] <= '0;
        end
      end
    end else if (w_row && w_wb) begin
      r_t[w_out][w_mid] <= round_clamp(w_acc, T_MIN, T_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_blk <= '0;
    end else if (w_col && w_wb) begin
      r_blk[w_out][w_mid] <=
        PIX_W'(round_clamp(w_acc, P_MIN, P_MAX));
    end
  end

  assign block      = r_blk;
  assign block_done = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_decompress_block.sv
// Scoreboard bench for decompress_block: stimulus pushes expected blocks,
// a negedge monitor pops and checks them on every block_done.
module tb_decompress_block;

  typedef logic [7:0][7:0][8:0]  pix_t;
  typedef logic [7:0][7:0][15:0] lvl_t;
  typedef struct {
    pix_t exp;
    int   n;
  } sb_t;

  logic clk = 1'b0;
  logic rst;
  logic start_block;
  lvl_t quantized_coeffs;
  pix_t block;
  logic block_done;
  logic busy;

  int cyc   = 0;
  int tests = 0;
  int fails = 0;
  int cosv [8][8];
  sb_t sbq [$];

`ifdef DECOMP_DEQUANT_EN
  int qt [8][8] = '{
    '{16, 11, 10, 16, 24, 40, 51, 61},
    '{12, 12, 14, 19, 26, 58, 60, 55},
    '{14, 13, 16, 24, 40, 57, 69, 56},
    '{14, 17, 22, 29, 51, 87, 80, 62},
    '{18, 22, 37, 56, 68, 109, 103, 77},
    '{24, 35, 55, 64, 81, 104, 113, 92},
    '{49, 64, 78, 87, 103, 121, 120, 101},
    '{72, 92, 95, 98, 112, 100, 103, 99}
  };
  localparam int DC_LV = 8;
`else
  localparam int DC_LV = 128;
`endif

  decompress_block dut (
    .clk              (clk),
    .rst              (rst),
    .start_block      (start_block),
    .quantized_coeffs (quantized_coeffs),
    .block            (block),
    .block_done       (block_done),
    .busy             (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint qmul(input int v, input int u);
`ifdef DECOMP_DEQUANT_EN
    return longint'(qt[v][u]);
`else
    return (v >= 0 && u >= 0) ? 64'sd1 : 64'sd1;
`endif
  endfunction

  function automatic longint rnd(input longint a,
                                 input longint lo,
                                 input longint hi);
    longint r;
    r = (a + 2048) >>> 12;
    if (r < lo) r = lo;
    if (r > hi) r = hi;
    return r;
  endfunction

  function automatic pix_t model(input lvl_t lv);
    longint d [8][8];
    longint t [8][8];
    longint acc;
    pix_t p;
    for (int v = 0; v < 8; v++)
      for (int u = 0; u < 8; u++)
        d[v][u] = longint'($signed(lv[v][u])) * qmul(v, u);
    for (int v = 0; v < 8; v++)
      for (int x = 0; x < 8; x++) begin
        acc = 0;
        for (int u = 0; u < 8; u++) acc += d[v][u] * longint'(cosv[x][u]);
        t[v][x] = rnd(acc, -64'sd8388608, 64'sd8388607);
      end
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        acc = 0;
        for (int v = 0; v < 8; v++) acc += t[v][x] * longint'(cosv[y][v]);
        p[y][x] = 9'(rnd(acc, -128, 127));
      end
    return p;
  endfunction

  function automatic pix_t fill(input int val);
    pix_t p;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) p[y][x] = 9'(val);
    return p;
  endfunction

  function automatic lvl_t dc_lvl(input int val);
    lvl_t l;
    l = '0;
    l[0][0] = 16'(val);
    return l;
  endfunction

  function automatic lvl_t rand_lvl();
    lvl_t l;
    for (int v = 0; v < 8; v++)
      for (int u = 0; u < 8; u++)
        l[v][u] = 16'(int'($urandom_range(0, 127)) - 64);
    return l;
  endfunction

  task automatic chk(input string name, input longint got, input longint want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // monitor: every block_done must match the oldest pending expectation
  always @(negedge clk) begin
    if (rst === 1'b0 && block_done === 1'b1) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done at cycle %0d want none", cyc);
      end else begin
        sb_t e;
        bit shown;
        e = sbq.pop_front();
        tests++;
        if (cyc != e.n + 1025) begin
          fails++;
          $display("FAIL latency: got %0d want %0d", cyc - e.n, 1025);
        end
        tests++;
        if (block !== e.exp) begin
          fails++;
          shown = 0;
          for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
              if (!shown && block[y][x] !== e.exp[y][x]) begin
                shown = 1;
                $display("FAIL block_data y=%0d x=%0d: got %0d want %0d",
                         y, x, $signed(block[y][x]), $signed(e.exp[y][x]));
              end
        end
      end
    end
  end

  task automatic run_block(input lvl_t lv, input pix_t ex, input bit dbl);
    int  n;
    bit  seen;
    bit  busy_ok;
    sb_t e;
    @(negedge clk);
    quantized_coeffs = lv;
    start_block = 1'b1;
    @(negedge clk);
    start_block = 1'b0;
    n = cyc;
    e.exp = ex;
    e.n = n;
    sbq.push_back(e);
    quantized_coeffs = rand_lvl();
    seen = 0;
    busy_ok = 1;
    for (int k = 0; k < 1100 && !seen; k++) begin
      if (busy !== 1'b1) busy_ok = 0;
      if (block_done === 1'b1) begin
        seen = 1;
      end else begin
        if (dbl && cyc == n + 299) start_block = 1'b1;
        @(negedge clk);
        start_block = 1'b0;
      end
    end
    chk("done_seen", longint'(seen), 1);
    chk("busy_while_running", longint'(busy_ok), 1);
    @(negedge clk);
    chk("busy_after_done", longint'(busy), 0);
    chk("done_single_pulse", longint'(block_done), 0);
  endtask

  initial begin
    int n;
    for (int x = 0; x < 8; x++)
      for (int u = 0; u < 8; u++) begin
        real c;
        real val;
        c = (u == 0) ? 1.0 / $sqrt(2.0) : 1.0;
        val = 2048.0 * c * $cos(real'((2 * x + 1) * u) * 3.14159265358979 / 16.0);
        cosv[x][u] = (val >= 0.0) ? $rtoi(val + 0.5) : -$rtoi(0.5 - val);
      end

    rst = 1'b1;
    start_block = 1'b0;
    quantized_coeffs = rand_lvl();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_block_zero", longint'(block == '0), 1);
    chk("reset_busy", longint'(busy), 0);
    chk("reset_done", longint'(block_done), 0);

    run_block('0, fill(0), 0);
    run_block(dc_lvl(DC_LV), fill(16), 0);
    run_block(dc_lvl(-DC_LV), fill(-16), 0);
    run_block(dc_lvl(2047), fill(127), 0);
    run_block(dc_lvl(-2048), fill(-128), 0);
    run_block(dc_lvl(DC_LV), fill(16), 1);

    // abort mid-block with a one-cycle reset
    @(negedge clk);
    quantized_coeffs = rand_lvl();
    start_block = 1'b1;
    @(negedge clk);
    start_block = 1'b0;
    n = cyc;
    while (cyc < n + 599) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_block_zero", longint'(block == '0), 1);
    chk("abort_busy", longint'(busy), 0);
    repeat (1100) @(negedge clk);
    chk("abort_still_idle", longint'(busy), 0);

    // start coincident with reset must not begin a block
    rst = 1'b1;
    start_block = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start_block = 1'b0;
    @(negedge clk);
    chk("rst_beats_start", longint'(busy), 0);

    run_block(dc_lvl(-DC_LV), fill(-16), 0);

    for (int b = 0; b < 40; b++) begin
      lvl_t l;
      l = rand_lvl();
      run_block(l, model(l), 0);
    end

    chk("scoreboard_empty", longint'(sbq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
